// File: rtl/max1270_pkg.sv
// Shared definitions for the MAX1270 sample packer.
// Holds the FSM state encoding, channel count, sample width, the header tag
// and a helper that picks the lowest enabled channel from a mask.
// Optional feature macro: MAX1270_PACKER_HEADER_EN adds the HDR state.
package max1270_pkg;

    localparam int unsigned MAX1270_CH_NUM  = 8;
    localparam int unsigned MAX1270_DATA_W  = 12;
    localparam logic [3:0]  MAX1270_HDR_TAG = 4'hF;

`ifdef MAX1270_PACKER_HEADER_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SNAP = 2'd1,
        ST_SEND = 2'd2,
        ST_HDR  = 2'd3
    } max1270_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SNAP = 2'd1,
        ST_SEND = 2'd2
    } max1270_state_e;
`endif

    // Index of the lowest set bit; returns 0 for an all-zero mask.
    function automatic logic [2:0] max1270_first_set(input logic [7:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/max1270_sample_packer_if.sv
// AXI4-Stream style output channel of the sample packer.
// tdata[15:12] channel tag (or header tag), tdata[11:0] payload.
// master: drives tdata/tvalid/tlast, samples tready. slave: the reverse.
interface max1270_sample_packer_if;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/max1270_frame_timer.sv
// Frame period timer: counts 0..period while enable is high and emits a
// registered one-cycle tick on the wrap; period=0 ticks every cycle.
// Ports: clk, rst_n (async active-low), enable, period, tick.
module max1270_frame_timer #(
    parameter int unsigned PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    tick
);

    logic [PERIOD_WIDTH-1:0] count_r;
    logic                    tick_r;

    // Period counter and tick; >= keeps the counter bounded if period shrinks mid-count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
            tick_r  <= 1'b0;
        end else if (!enable) begin
            count_r <= '0;
            tick_r  <= 1'b0;
        end else if (count_r >= period) begin
            count_r <= '0;
            tick_r  <= 1'b1;
        end else begin
            count_r <= count_r + {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
            tick_r  <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/max1270_sample_packer.sv
// MAX1270 sample packer: on each frame tick, snapshots the eight held
// channel results plus the channel mask, then streams the enabled channels
// in ascending order as {tag, sample} beats with tlast on the highest one.
// Ticks that arrive while a frame is busy are dropped and counted.
// Ports: s_axil_clk, s_axil_rst (async active-low), iADCh0..7Data, iEnable,
// iChMask, iPeriod, m_axis (stream master), oOverrunCnt, oBusy.
// Optional feature macro: MAX1270_PACKER_HEADER_EN prepends a header beat
// {4'hF, frame_count[11:0]} to every frame.
module max1270_sample_packer
    import max1270_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = 24,
    parameter int unsigned OVR_WIDTH    = 16
) (
    input  logic                          s_axil_clk,
    input  logic                          s_axil_rst,
    input  logic [MAX1270_DATA_W-1:0]     iADCh0Data,
    input  logic [MAX1270_DATA_W-1:0]     iADCh1Data,
    input  logic [MAX1270_DATA_W-1:0]     iADCh2Data,
    input  logic [MAX1270_DATA_W-1:0]     iADCh3Data,
    input  logic [MAX1270_DATA_W-1:0]     iADCh4Data,
    input  logic [MAX1270_DATA_W-1:0]     iADCh5Data,
    input  logic [MAX1270_DATA_W-1:0]     iADCh6Data,
    input  logic [MAX1270_DATA_W-1:0]     iADCh7Data,
    input  logic                          iEnable,
    input  logic [MAX1270_CH_NUM-1:0]     iChMask,
    input  logic [PERIOD_WIDTH-1:0]       iPeriod,
    max1270_sample_packer_if.master       m_axis,
    output logic [OVR_WIDTH-1:0]          oOverrunCnt,
    output logic                          oBusy
);

    logic                      tick_s;
    logic [MAX1270_DATA_W-1:0] live_s   [MAX1270_CH_NUM];
    logic [MAX1270_DATA_W-1:0] shadow_r [MAX1270_CH_NUM];
    logic [MAX1270_CH_NUM-1:0] pending_r;
    max1270_state_e            state_r;
    logic [15:0]               tdata_r;
    logic                      tvalid_r;
    logic                      tlast_r;
    logic [OVR_WIDTH-1:0]      ovr_r;
    logic                      busy_r;
    logic                      xfer_s;
    logic [MAX1270_CH_NUM-1:0] src_mask_s;
    logic [2:0]                beat_idx_s;
    logic [MAX1270_DATA_W-1:0] beat_sample_s;
    logic [MAX1270_CH_NUM-1:0] rest_mask_s;
`ifdef MAX1270_PACKER_HEADER_EN
    logic [11:0]               frame_cnt_r;
`endif

    max1270_frame_timer #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_timer (
        .clk    (s_axil_clk),
        .rst_n  (s_axil_rst),
        .enable (iEnable),
        .period (iPeriod),
        .tick   (tick_s)
    );

    assign live_s[0] = iADCh0Data;
    assign live_s[1] = iADCh1Data;
    assign live_s[2] = iADCh2Data;
    assign live_s[3] = iADCh3Data;
    assign live_s[4] = iADCh4Data;
    assign live_s[5] = iADCh5Data;
    assign live_s[6] = iADCh6Data;
    assign live_s[7] = iADCh7Data;

    assign xfer_s = tvalid_r & m_axis.tready;

    // Next-beat selection. In SNAP the first beat comes straight from the live
    // inputs, which are the very values being latched into the shadows that edge.
    always_comb begin
        src_mask_s    = pending_r;
        beat_sample_s = '0;
        if (state_r == ST_SNAP) begin
            src_mask_s = iChMask;
        end else begin
            src_mask_s = pending_r;
        end
        beat_idx_s = max1270_first_set(src_mask_s);
        if (state_r == ST_SNAP) begin
            beat_sample_s = live_s[beat_idx_s];
        end else begin
            beat_sample_s = shadow_r[beat_idx_s];
        end
        rest_mask_s = src_mask_s & ~(8'h01 << beat_idx_s);
    end

    // Frame FSM with registered stream outputs, busy flag and overrun counter.
    always_ff @(posedge s_axil_clk or negedge s_axil_rst) begin
        if (!s_axil_rst) begin
            state_r   <= ST_IDLE;
            pending_r <= '0;
            tdata_r   <= 16'h0000;
            tvalid_r  <= 1'b0;
            tlast_r   <= 1'b0;
            ovr_r     <= '0;
            busy_r    <= 1'b0;
            for (int i = 0; i < int'(MAX1270_CH_NUM); i++) begin
                shadow_r[i] <= '0;
            end
`ifdef MAX1270_PACKER_HEADER_EN
            frame_cnt_r <= 12'd0;
`endif
        end else begin
            // Any tick outside IDLE is a dropped snapshot, including one that
            // lands on the final accepted beat.
            if (tick_s && (state_r != ST_IDLE) && (ovr_r != {OVR_WIDTH{1'b1}})) begin
                ovr_r <= ovr_r + {{(OVR_WIDTH-1){1'b0}}, 1'b1};
            end
            case (state_r)
                ST_IDLE: begin
                    if (tick_s && (iChMask != 8'h00)) begin
                        state_r <= ST_SNAP;
                        busy_r  <= 1'b1;
                    end
                end
                ST_SNAP: begin
                    for (int i = 0; i < int'(MAX1270_CH_NUM); i++) begin
                        shadow_r[i] <= live_s[i];
                    end
                    if (iChMask == 8'h00) begin
                        // Mask cleared between tick and snapshot: nothing to send.
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
`ifdef MAX1270_PACKER_HEADER_EN
                        pending_r <= iChMask;
                        tdata_r   <= {MAX1270_HDR_TAG, frame_cnt_r};
                        tvalid_r  <= 1'b1;
                        tlast_r   <= 1'b0;
                        state_r   <= ST_HDR;
`else
                        pending_r <= rest_mask_s;
                        tdata_r   <= {1'b0, beat_idx_s, beat_sample_s};
                        tvalid_r  <= 1'b1;
                        tlast_r   <= (rest_mask_s == 8'h00);
                        state_r   <= ST_SEND;
`endif
                    end
                end
`ifdef MAX1270_PACKER_HEADER_EN
                ST_HDR: begin
                    if (xfer_s) begin
                        pending_r <= rest_mask_s;
                        tdata_r   <= {1'b0, beat_idx_s, beat_sample_s};
                        tlast_r   <= (rest_mask_s == 8'h00);
                        state_r   <= ST_SEND;
                    end
                end
`endif
                ST_SEND: begin
                    if (xfer_s) begin
                        if (tlast_r) begin
                            state_r  <= ST_IDLE;
                            tdata_r  <= 16'h0000;
                            tvalid_r <= 1'b0;
                            tlast_r  <= 1'b0;
                            busy_r   <= 1'b0;
`ifdef MAX1270_PACKER_HEADER_EN
                            frame_cnt_r <= frame_cnt_r + 12'd1;
`endif
                        end else begin
                            pending_r <= rest_mask_s;
                            tdata_r   <= {1'b0, beat_idx_s, beat_sample_s};
                            tlast_r   <= (rest_mask_s == 8'h00);
                        end
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    tdata_r  <= 16'h0000;
                    tvalid_r <= 1'b0;
                    tlast_r  <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis.tdata  = tdata_r;
    assign m_axis.tvalid = tvalid_r;
    assign m_axis.tlast  = tlast_r;
    assign oOverrunCnt   = ovr_r;
    assign oBusy         = busy_r;

endmodule

// File: tb/tb_max1270_sample_packer.sv
// Self-checking bench for max1270_sample_packer (builds with or without
// MAX1270_PACKER_HEADER_EN). Expected beats are pushed to a queue when a
// frame is set up and popped as the DUT transfers beats.
module tb_max1270_sample_packer;
    import max1270_pkg::*;

    localparam int OVR_W = 4;
`ifdef MAX1270_PACKER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    // Full frames need one extra cycle per period when the header beat exists.
    localparam int P_FULL = 9 + HDR;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] ch_data [8];
    logic        enable;
    logic [7:0]  mask;
    logic [23:0] period;
    logic [OVR_W-1:0] ovr;
    logic        busy;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    beat_t       exp_q [$];
    logic [11:0] exp_frame = 12'd0;

    max1270_sample_packer_if axis_if ();

    max1270_sample_packer #(
        .PERIOD_WIDTH (24),
        .OVR_WIDTH    (OVR_W)
    ) dut (
        .s_axil_clk  (clk),
        .s_axil_rst  (rst),
        .iADCh0Data  (ch_data[0]),
        .iADCh1Data  (ch_data[1]),
        .iADCh2Data  (ch_data[2]),
        .iADCh3Data  (ch_data[3]),
        .iADCh4Data  (ch_data[4]),
        .iADCh5Data  (ch_data[5]),
        .iADCh6Data  (ch_data[6]),
        .iADCh7Data  (ch_data[7]),
        .iEnable     (enable),
        .iChMask     (mask),
        .iPeriod     (period),
        .m_axis      (axis_if),
        .oOverrunCnt (ovr),
        .oBusy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_channels(input logic [11:0] base);
        for (int n = 0; n < 8; n++) ch_data[n] = base + 12'(n);
    endtask

    // Reference model: one frame of expected beats from the current inputs.
    task automatic push_frame(input logic [7:0] m);
        beat_t b;
        int hi;
        hi = -1;
        for (int n = 0; n < 8; n++) if (m[n]) hi = n;
`ifdef MAX1270_PACKER_HEADER_EN
        b.data = {4'hF, exp_frame};
        b.last = 1'b0;
        exp_q.push_back(b);
        exp_frame = exp_frame + 12'd1;
`endif
        for (int n = 0; n < 8; n++) begin
            if (m[n]) begin
                b.data = {n[3:0], ch_data[n]};
                b.last = (n == hi);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || axis_if.tvalid) && g < 200) begin step(); g++; end
        n_checks++;
        if (busy || axis_if.tvalid) begin
            n_fail++;
            $display("FAIL idle_timeout busy=%b tvalid=%b want 0/0", busy, axis_if.tvalid);
        end
        step(); step();
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; mask = 8'h00; period = 24'd0;
        axis_if.tready = 1'b0;
        set_channels(12'h000);
        step(); step();
        n_checks++; if (axis_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid got %b want 0", axis_if.tvalid); end
        n_checks++; if (axis_if.tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast got %b want 0", axis_if.tlast); end
        n_checks++; if (axis_if.tdata !== 16'h0000) begin n_fail++; $display("FAIL rst_tdata got %h want 0000", axis_if.tdata); end
        n_checks++; if (ovr !== 4'd0) begin n_fail++; $display("FAIL rst_ovr got %0d want 0", ovr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_full_frames();
        beat_t e;
        int en_cyc, prev_cyc, prev_start, exp_start, bif, fno, g;
        period = 24'(P_FULL); mask = 8'hFF; axis_if.tready = 1'b1;
        set_channels(12'h100);
        for (int f = 0; f < 3; f++) push_frame(8'hFF);
        enable = 1'b1; en_cyc = cyc;
        bif = 0; fno = 0; g = 0; prev_cyc = 0; prev_start = 0;
        while (exp_q.size() > 0 && g < 400) begin
            step(); g++;
            if (axis_if.tvalid && axis_if.tready) begin
                e = exp_q.pop_front();
                n_checks++;
                if (axis_if.tdata !== e.data || axis_if.tlast !== e.last) begin
                    n_fail++;
                    $display("FAIL full_beat got %h/%b want %h/%b", axis_if.tdata, axis_if.tlast, e.data, e.last);
                end
                n_checks++;
                if (bif == 0) begin
                    exp_start = (fno == 0) ? en_cyc + P_FULL + 3 : prev_start + P_FULL + 1;
                    if (cyc !== exp_start) begin n_fail++; $display("FAIL full_start got cyc %0d want %0d", cyc, exp_start); end
                    prev_start = cyc; fno++;
                end else begin
                    if (cyc !== prev_cyc + 1) begin n_fail++; $display("FAIL full_b2b got cyc %0d want %0d", cyc, prev_cyc + 1); end
                end
                prev_cyc = cyc;
                bif = e.last ? 0 : bif + 1;
            end
        end
        enable = 1'b0;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_timeout left %0d want 0", exp_q.size()); end
        exp_q.delete();
        wait_idle();
    endtask

    task automatic test_sparse_mask();
        beat_t e;
        int g;
        period = 24'd9; mask = 8'b1010_0100; axis_if.tready = 1'b1;
        set_channels(12'h200);
        push_frame(mask); push_frame(mask);
        enable = 1'b1; g = 0;
        while (exp_q.size() > 0 && g < 200) begin
            step(); g++;
            if (axis_if.tvalid && axis_if.tready) begin
                e = exp_q.pop_front();
                n_checks++;
                if (axis_if.tdata !== e.data || axis_if.tlast !== e.last) begin
                    n_fail++;
                    $display("FAIL sparse_beat got %h/%b want %h/%b", axis_if.tdata, axis_if.tlast, e.data, e.last);
                end
            end
        end
        enable = 1'b0;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sparse_timeout left %0d want 0", exp_q.size()); end
        exp_q.delete();
        wait_idle();
    endtask

    task automatic test_zero_mask();
        int seen_v, seen_b;
        logic [OVR_W-1:0] ovr0;
        period = 24'd1; mask = 8'h00; axis_if.tready = 1'b1;
        ovr0 = ovr; seen_v = 0; seen_b = 0;
        enable = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step();
            if (axis_if.tvalid) seen_v++;
            if (busy) seen_b++;
        end
        enable = 1'b0;
        n_checks++; if (seen_v != 0) begin n_fail++; $display("FAIL zero_tvalid got %0d cycles want 0", seen_v); end
        n_checks++; if (seen_b != 0) begin n_fail++; $display("FAIL zero_busy got %0d cycles want 0", seen_b); end
        n_checks++; if (ovr !== ovr0) begin n_fail++; $display("FAIL zero_ovr got %0d want %0d", ovr, ovr0); end
        step(); step();
    endtask

    task automatic test_snapshot_stall();
        beat_t e;
        int g;
        logic changed, pv, pr, pl;
        logic [15:0] pd;
        period = 24'd40; mask = 8'hFF; axis_if.tready = 1'b1;
        set_channels(12'h400);
        push_frame(8'hFF);
        enable = 1'b1; g = 0; changed = 1'b0; pv = 1'b0; pr = 1'b0; pd = 16'h0000; pl = 1'b0;
        while (exp_q.size() > 0 && g < 300) begin
            step(); g++;
            if (pv && !pr) begin
                n_checks++;
                if (axis_if.tvalid !== 1'b1 || axis_if.tdata !== pd || axis_if.tlast !== pl) begin
                    n_fail++;
                    $display("FAIL stall_hold got %b/%h/%b want 1/%h/%b", axis_if.tvalid, axis_if.tdata, axis_if.tlast, pd, pl);
                end
            end
            if (axis_if.tvalid && !changed) begin
                // Inputs and mask move under an active frame: only the next frame sees them.
                set_channels(12'hA50);
                mask = 8'h81;
                push_frame(8'h81);
                changed = 1'b1;
            end
            axis_if.tready = ($urandom_range(0, 3) != 0);
            if (axis_if.tvalid && axis_if.tready) begin
                e = exp_q.pop_front();
                n_checks++;
                if (axis_if.tdata !== e.data || axis_if.tlast !== e.last) begin
                    n_fail++;
                    $display("FAIL snap_beat got %h/%b want %h/%b", axis_if.tdata, axis_if.tlast, e.data, e.last);
                end
            end
            pv = axis_if.tvalid; pr = axis_if.tready; pd = axis_if.tdata; pl = axis_if.tlast;
        end
        enable = 1'b0; axis_if.tready = 1'b1;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL snap_timeout left %0d want 0", exp_q.size()); end
        exp_q.delete();
        wait_idle();
    endtask

    task automatic test_overrun();
        beat_t e;
        int g, en_cyc, base, want;
        logic [15:0] hd;
        logic hl;
        period = 24'd2; mask = 8'hFF; axis_if.tready = 1'b0;
        set_channels(12'h300);
        push_frame(8'hFF);
        base = int'(ovr);
        enable = 1'b1; en_cyc = cyc; g = 0;
        while (!axis_if.tvalid && g < 20) begin step(); g++; end
        n_checks++; if (cyc !== en_cyc + 5) begin n_fail++; $display("FAIL ovr_first got cyc %0d want %0d", cyc, en_cyc + 5); end
        hd = axis_if.tdata; hl = axis_if.tlast;
        n_checks++; if (int'(ovr) !== base) begin n_fail++; $display("FAIL ovr_count0 got %0d want %0d", ovr, base); end
        for (int k = 1; k <= 20; k++) begin
            for (int s = 0; s < 3; s++) begin
                step();
                n_checks++;
                if (axis_if.tvalid !== 1'b1 || axis_if.tdata !== hd || axis_if.tlast !== hl) begin
                    n_fail++;
                    $display("FAIL ovr_hold got %b/%h/%b want 1/%h/%b", axis_if.tvalid, axis_if.tdata, axis_if.tlast, hd, hl);
                end
            end
            want = (base + k > 15) ? 15 : base + k;
            n_checks++; if (int'(ovr) !== want) begin n_fail++; $display("FAIL ovr_count got %0d want %0d", ovr, want); end
        end
        n_checks++; if (ovr !== 4'd15) begin n_fail++; $display("FAIL ovr_sat got %0d want 15", ovr); end
        enable = 1'b0; axis_if.tready = 1'b1; g = 0;
        while (exp_q.size() > 0 && g < 100) begin
            if (axis_if.tvalid && axis_if.tready) begin
                e = exp_q.pop_front();
                n_checks++;
                if (axis_if.tdata !== e.data || axis_if.tlast !== e.last) begin
                    n_fail++;
                    $display("FAIL ovr_beat got %h/%b want %h/%b", axis_if.tdata, axis_if.tlast, e.data, e.last);
                end
            end
            step(); g++;
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovr_timeout left %0d want 0", exp_q.size()); end
        exp_q.delete();
        wait_idle();
        n_checks++; if (ovr !== 4'd15) begin n_fail++; $display("FAIL ovr_keep got %0d want 15", ovr); end
    endtask

    task automatic test_reset_mid_send();
        beat_t e;
        int g, got, en_cyc;
        period = 24'(P_FULL); mask = 8'hFF; axis_if.tready = 1'b1;
        set_channels(12'h500);
        push_frame(8'hFF);
        enable = 1'b1; g = 0; got = 0;
        while (got < 3 + HDR && g < 100) begin
            step(); g++;
            if (axis_if.tvalid && axis_if.tready) begin
                e = exp_q.pop_front(); got++;
                n_checks++;
                if (axis_if.tdata !== e.data) begin n_fail++; $display("FAIL rmid_beat got %h want %h", axis_if.tdata, e.data); end
            end
        end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (axis_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_tvalid got %b want 0", axis_if.tvalid); end
        n_checks++; if (ovr !== 4'd0) begin n_fail++; $display("FAIL rmid_ovr got %0d want 0", ovr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
        exp_q.delete(); exp_frame = 12'd0;
        step(); step();
        rst = 1'b1; en_cyc = cyc;
        push_frame(8'hFF);
        g = 0;
        while (!axis_if.tvalid && g < 40) begin step(); g++; end
        n_checks++; if (cyc !== en_cyc + P_FULL + 3) begin n_fail++; $display("FAIL rmid_restart got cyc %0d want %0d", cyc, en_cyc + P_FULL + 3); end
        g = 0;
        while (exp_q.size() > 0 && g < 40) begin
            if (axis_if.tvalid && axis_if.tready) begin
                e = exp_q.pop_front();
                n_checks++;
                if (axis_if.tdata !== e.data || axis_if.tlast !== e.last) begin
                    n_fail++;
                    $display("FAIL rmid_frame got %h/%b want %h/%b", axis_if.tdata, axis_if.tlast, e.data, e.last);
                end
                if (e.last) enable = 1'b0;
            end
            step(); g++;
        end
        enable = 1'b0;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rmid_timeout left %0d want 0", exp_q.size()); end
        exp_q.delete();
        wait_idle();
    endtask

    task automatic test_header();
        beat_t e;
        int g, n_hdr, n_frames, lim;
`ifdef MAX1270_PACKER_HEADER_EN
        // One frame already completed since the last reset; 4096 more wraps 4095 -> 0.
        n_frames = 4096; period = 24'd3; mask = 8'h01;
`else
        n_frames = 3; period = 24'd9; mask = 8'hFF;
`endif
        axis_if.tready = 1'b1;
        set_channels(12'h600);
        for (int f = 0; f < n_frames; f++) push_frame(mask);
        lim = n_frames * (int'(period) + 1) + 100;
        enable = 1'b1; g = 0; n_hdr = 0;
        while (exp_q.size() > 0 && g < lim) begin
            step(); g++;
            if (axis_if.tvalid && axis_if.tready) begin
                e = exp_q.pop_front();
                if (axis_if.tdata[15:12] == 4'hF) n_hdr++;
                n_checks++;
                if (axis_if.tdata !== e.data || axis_if.tlast !== e.last) begin
                    n_fail++;
                    $display("FAIL hdr_beat got %h/%b want %h/%b", axis_if.tdata, axis_if.tlast, e.data, e.last);
                end
                if (exp_q.size() == 0) enable = 1'b0;
            end
        end
        enable = 1'b0;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL hdr_timeout left %0d want 0", exp_q.size()); end
        n_checks++; if (n_hdr != n_frames * HDR) begin n_fail++; $display("FAIL hdr_tags got %0d want %0d", n_hdr, n_frames * HDR); end
`ifdef MAX1270_PACKER_HEADER_EN
        n_checks++; if (exp_frame !== 12'd1) begin n_fail++; $display("FAIL hdr_wrap model %0d want 1", exp_frame); end
`endif
        exp_q.delete();
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_full_frames();
        test_sparse_mask();
        test_zero_mask();
        test_snapshot_stall();
        test_overrun();
        test_reset_mid_send();
        test_header();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
